if_id: RTL and testbench

IF_ID -- requirements
Module: IF_ID

---
 rtl/if_id.sv | 40 ++++
 tb/tb_if_id.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/if_id.sv
// IF/ID pipeline register: captures instruction and PC for the decode stage.
// Latency one clk edge; IFID_write=0 stalls (holds both values), startin clears both.
module if_id #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32
) (
  input  logic               startin,
  input  logic               clk,
  input  logic [INSTR_W-1:0] instruction,
  input  logic [PC_W-1:0]    pcIn,
  output logic [INSTR_W-1:0] ins,
  output logic [PC_W-1:0]    pc,
  input  logic               IFID_write
);

  logic [INSTR_W-1:0] ins_q, ins_d;
  logic [PC_W-1:0]    pc_q, pc_d;

  // Reset outranks the load enable; both fields share one select so they never split.
  always_comb begin
    ins_d = ins_q;
    pc_d  = pc_q;
    if (startin) begin
      ins_d = '0;
      pc_d  = '0;
    end else if (IFID_write) begin
      ins_d = instruction;
      pc_d  = pcIn;
    end
  end

  always_ff @(posedge clk) begin
    ins_q <= ins_d;
    pc_q  <= pc_d;
  end

  assign ins = ins_q;
  assign pc  = pc_q;

endmodule

// File: tb/tb_if_id.sv
// Directed bench for if_id: reference model plus per-cycle compare and literal checkpoints.
module tb_if_id;

  logic        clk = 1'b0;
  logic        startin;
  logic [31:0] instruction;
  logic [31:0] pcIn;
  logic [31:0] ins;
  logic [31:0] pc;
  logic        IFID_write;

  int checks = 0;
  int errors = 0;

  if_id #(.INSTR_W(32), .PC_W(32)) dut (
    .startin     (startin),
    .clk         (clk),
    .instruction (instruction),
    .pcIn        (pcIn),
    .ins         (ins),
    .pc          (pc),
    .IFID_write  (IFID_write)
  );

  always #5 clk = ~clk;

  // Reference model: the outputs are whatever was last captured, or zero after a reset edge.
  logic [31:0] m_ins, m_pc;
  bit          m_known = 1'b0;

  always @(posedge clk) begin
    if (startin) begin
      m_ins   = 32'h0;
      m_pc    = 32'h0;
      m_known = 1'b1;
    end else if (IFID_write) begin
      m_ins   = instruction;
      m_pc    = pcIn;
      m_known = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      checks++;
      if (ins !== m_ins || pc !== m_pc) begin
        errors++;
        $display("FAIL model_cmp t=%0t ins=%h pc=%h expected ins=%h pc=%h",
                 $time, ins, pc, m_ins, m_pc);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic we, input logic [31:0] i, input logic [31:0] p);
    @(negedge clk);
    startin     = s;
    IFID_write  = we;
    instruction = i;
    pcIn        = p;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] stream_i [3] = '{32'hDEADBEEF, 32'h0000_0000, 32'hFFFFFFFF};
  logic [31:0] stream_p [3] = '{32'd16, 32'd20, 32'd24};

  initial begin
    startin = 1'b1; IFID_write = 1'b1; instruction = 32'd30; pcIn = 32'd8;

    // Reset wins over a simultaneous load
    step();
    chk("reset_ins", ins, 32'h0);
    chk("reset_pc",  pc,  32'h0);

    // Load appears only after the edge
    drive(1'b0, 1'b1, 32'd30, 32'd8);
    #1;
    chk("load_before_ins", ins, 32'h0);
    chk("load_before_pc",  pc,  32'h0);
    step();
    chk("load_ins", ins, 32'd30);
    chk("load_pc",  pc,  32'd8);

    // Three-cycle stall with inputs wiggling between edges
    drive(1'b0, 1'b0, 32'h12345678, 32'd12);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_ins", ins, 32'd30);
      chk("stall_pc",  pc,  32'd8);
      #2 instruction = 32'hA5A5A5A5;
      #1 instruction = 32'h12345678;
    end

    drive(1'b0, 1'b1, 32'h12345678, 32'd12);
    step();
    chk("resume_ins", ins, 32'h12345678);
    chk("resume_pc",  pc,  32'd12);

    // Mid-stream reset, held for several edges, with and without load enable
    drive(1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFC);
    step();
    chk("midrst_ins", ins, 32'h0);
    chk("midrst_pc",  pc,  32'h0);
    step();
    chk("rst_hold_ins", ins, 32'h0);
    drive(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFC);
    step();
    chk("rst_hold_pc", pc, 32'h0);

    // Back-to-back loads
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, stream_i[k], stream_p[k]);
      step();
      chk("stream_ins", ins, stream_i[k]);
      chk("stream_pc",  pc,  stream_p[k]);
    end

    // Long stall: full-width all-ones value must not decay
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (10) step();
    chk("long_stall_ins", ins, 32'hFFFFFFFF);
    chk("long_stall_pc",  pc,  32'd24);

    // Mixed random traffic, checked by the model every cycle
    for (int k = 0; k < 200; k++) begin
      drive(($urandom_range(0, 15) == 0), $urandom_range(0, 1), $urandom, $urandom);
    end
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
